// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-register pending-write scoreboard, RAW stall,
// taken-branch fetch/decode flush sequencing, stall statistics and deadlock flag.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned TIMEOUT      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [3:0]       dec_rs1,
    input  logic [3:0]       dec_rs2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [3:0]       dec_rd,
    input  logic             dec_rwrite,
    input  logic             branch_taken,
    input  logic [3:0]       wb_rd,
    input  logic             wb_rwrite,
    output logic             stall_fetch,
    output logic             bubble_exe,
    output logic             flush_deco,
    output logic [15:0]      busy_mask,
    output logic [CNT_W-1:0] stall_count,
    output logic             deadlock
);

    localparam int unsigned NREG = 16;
    localparam int unsigned PW   = 2;
    localparam int unsigned FW   = 2;
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [FW-1:0]  fcnt;
    logic [FW-1:0]  fcnt_next;

    logic [PW-1:0]  pend      [NREG];
    logic [PW-1:0]  pend_next [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [NREG-1:0] busy_next;

    logic [TW-1:0]  consec;

    logic hazard_c;
    logic flush_active_c;
    logic br_flush_c;
    logic issue_c;

    // RAW hazard against writes still in flight (including one writing back now)
    always_comb begin
        hazard_c = dec_valid & ((dec_use1 & (pend[dec_rs1] != '0)) |
                                (dec_use2 & (pend[dec_rs2] != '0)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    // Flush sequencing; a stalled branch is ignored since its operands are not ready
    always_comb begin
        state_next     = state;
        fcnt_next      = fcnt;
        flush_active_c = 1'b0;
        br_flush_c     = 1'b0;
        case (state)
            RUN: begin
                br_flush_c = branch_taken & dec_valid & ~hazard_c;
                if (br_flush_c && (FLUSH_CYCLES > 1)) begin
                    state_next = FLUSH;
                    fcnt_next  = FW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                flush_active_c = 1'b1;
                fcnt_next      = fcnt - 1'b1;
                if (fcnt == FW'(1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // While flushing, the decode slot is squashed, so it is never issued nor stalled
    always_comb begin
        issue_c     = dec_valid & ~hazard_c & ~flush_active_c;
        stall_fetch = ~reset & hazard_c & ~flush_active_c;
        bubble_exe  = ~reset & (hazard_c | flush_active_c);
        flush_deco  = ~reset & (br_flush_c | flush_active_c);
    end

    always_comb begin
        inc_vec = (issue_c & dec_rwrite) ? (NREG'(1) << dec_rd) : '0;
        dec_vec = wb_rwrite ? (NREG'(1) << wb_rd) : '0;
        for (int i = 0; i < NREG; i++) begin
            pend_next[i] = pend[i];
            if (inc_vec[i] && !dec_vec[i] && (pend[i] != 2'd3)) begin
                pend_next[i] = pend[i] + 2'd1;
            end else if (dec_vec[i] && !inc_vec[i] && (pend[i] != 2'd0)) begin
                pend_next[i] = pend[i] - 2'd1;
            end
            busy_next[i] = (pend_next[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                pend[i] <= '0;
            end
            busy_mask <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                pend[i] <= pend_next[i];
            end
            busy_mask <= busy_next;
        end
    end

    // Stall statistics; deadlock latches on the TIMEOUT-th consecutive stall cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            consec      <= '0;
            deadlock    <= 1'b0;
        end else if (stall_fetch) begin
            if (stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            if (consec != TW'(TIMEOUT)) begin
                consec <= consec + 1'b1;
            end
            if (consec >= TW'(TIMEOUT - 1)) begin
                deadlock <= 1'b1;
            end
        end else begin
            consec <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked every cycle against a behavioural model of the controller.
module tb_hazard_ctrl;

    localparam int unsigned FC = 3;
    localparam int unsigned CW = 6;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid;
    logic [3:0]    dec_rs1;
    logic [3:0]    dec_rs2;
    logic          dec_use1;
    logic          dec_use2;
    logic [3:0]    dec_rd;
    logic          dec_rwrite;
    logic          branch_taken;
    logic [3:0]    wb_rd;
    logic          wb_rwrite;
    logic          stall_fetch;
    logic          bubble_exe;
    logic          flush_deco;
    logic [15:0]   busy_mask;
    logic [CW-1:0] stall_count;
    logic          deadlock;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use1    (dec_use1),
        .dec_use2    (dec_use2),
        .dec_rd      (dec_rd),
        .dec_rwrite  (dec_rwrite),
        .branch_taken(branch_taken),
        .wb_rd       (wb_rd),
        .wb_rwrite   (wb_rwrite),
        .stall_fetch (stall_fetch),
        .bubble_exe  (bubble_exe),
        .flush_deco  (flush_deco),
        .busy_mask   (busy_mask),
        .stall_count (stall_count),
        .deadlock    (deadlock)
    );

    typedef struct packed {
        logic          sf;
        logic          be;
        logic          fd;
        logic [15:0]   busy;
        logic [CW-1:0] cnt;
        logic          dl;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;

    // Reference model: in-flight write counts, remaining flush slots, stall tallies
    int m_pend[16];
    int m_flush_left;
    int m_cnt;
    int m_consec;
    bit m_dl;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_flush_left = 0;
        m_cnt        = 0;
        m_consec     = 0;
        m_dl         = 0;
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[i] = (m_pend[i] > 0);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int v, input int rs1, input int rs2, input int u1, input int u2,
                        input int rd, input int rw, input int br, input int wrd, input int ww,
                        input int rst);
        exp_t e;
        bit   fl, haz, iss, bf, inc, dcr;
        dec_valid    = 1'(v);
        dec_rs1      = 4'(rs1);
        dec_rs2      = 4'(rs2);
        dec_use1     = 1'(u1);
        dec_use2     = 1'(u2);
        dec_rd       = 4'(rd);
        dec_rwrite   = 1'(rw);
        branch_taken = 1'(br);
        wb_rd        = 4'(wrd);
        wb_rwrite    = 1'(ww);
        reset        = 1'(rst);

        e.busy = model_busy();
        e.cnt  = CW'(m_cnt);
        e.dl   = m_dl;
        if (rst != 0) begin
            e.sf = 0;
            e.be = 0;
            e.fd = 0;
            model_reset();
        end else begin
            fl  = (m_flush_left > 0);
            haz = !fl && (v != 0) && (((u1 != 0) && m_pend[rs1] > 0) || ((u2 != 0) && m_pend[rs2] > 0));
            iss = (v != 0) && !haz && !fl;
            bf  = !fl && !haz && (v != 0) && (br != 0);
            e.sf = haz;
            e.be = haz || fl;
            e.fd = fl || bf;
            inc = iss && (rw != 0);
            dcr = (ww != 0);
            if (inc && !(dcr && wrd == rd) && m_pend[rd] < 3) m_pend[rd]++;
            if (dcr && !(inc && wrd == rd) && m_pend[wrd] > 0) m_pend[wrd]--;
            if (haz) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                m_consec++;
                if (m_consec >= TO) m_dl = 1;
            end else begin
                m_consec = 0;
            end
            if (fl) m_flush_left--;
            else if (bf) m_flush_left = FC - 1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst1();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: one expected record per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (q.size() == 0) begin
                    chk("queue_empty", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("stall_fetch", 32'(stall_fetch), 32'(e.sf));
                    chk("bubble_exe",  32'(bubble_exe),  32'(e.be));
                    chk("flush_deco",  32'(flush_deco),  32'(e.fd));
                    chk("busy_mask",   32'(busy_mask),   32'(e.busy));
                    chk("stall_count", 32'(stall_count), 32'(e.cnt));
                    chk("deadlock",    32'(deadlock),    32'(e.dl));
                end
            end
        end
    end

    initial begin
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use1 = 0; dec_use2 = 0;
        dec_rd = 0; dec_rwrite = 0; branch_taken = 0; wb_rd = 0; wb_rwrite = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        started = 1;

        // reset then idle
        rst1();
        nop(3);

        // r3 written, reader stalls, writeback cycle still stalls, then release
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 3, 1, 0);
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(2);

        // two writes to r5, same-cycle inc+dec, then drain
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0);
        step(1, 0, 0, 0, 0, 5, 1, 0, 5, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0);
        nop(1);

        // taken branch: multi-cycle flush, branch during flush ignored
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop(2);

        // branch held back by a pending operand, flushes once it clears
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        step(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 2, 0, 1, 0, 0, 1, 2, 1, 0);
        step(1, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0);
        nop(3);

        // deadlock: reader of r7 never released, then reset mid-stall
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        repeat (12) step(1, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        rst1();
        nop(2);

        // random traffic on a small register window to keep hazards frequent
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) < 8) ? 1 : 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 ($urandom_range(0, 499) == 0) ? 1 : 0);
        end

        chk("queue_drain", 32'(q.size()), 32'(0));
        started = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core (fetch, decode, execute, memory, writeback).
- Keeps a per-register scoreboard of in-flight writes and stalls fetch/decode on read-after-write hazards.
- Inserts bubbles into the decode→execute register and flushes fetch→decode after a taken branch resolved in decode.
- Provides stall statistics and a sticky deadlock flag.

Parameters:
FLUSH_CYCLES, 1, cycles of fetch→decode squash after a taken branch (1..3)
CNT_W, 16, width of saturating stall-cycle counter
TIMEOUT, 8, consecutive stall cycles before deadlock flag sets

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dec_valid  in  1  decode stage holds a real instruction
dec_rs1  in  4  decode source register 1 (instr bits 22:19)
dec_rs2  in  4  decode source register 2 (instr bits 18:15)
dec_use1  in  1  instruction reads rs1
dec_use2  in  1  instruction reads rs2
dec_rd  in  4  decode destination (instr bits 26:23)
dec_rwrite  in  1  instruction writes register file
branch_taken  in  1  decode-stage branch taken (PC select)
wb_rd  in  4  writeback destination
wb_rwrite  in  1  writeback writes register file this cycle
stall_fetch  out  1  hold PC and fetch→decode register
bubble_exe  out  1  load NOP (all control zero) into decode→execute register
flush_deco  out  1  load NOP into fetch→decode register
busy_mask  out  16  bit i = register i has ≥1 pending write
stall_count  out  CNT_W  total stall cycles, saturating
deadlock  out  1  sticky: stall persisted ≥ TIMEOUT cycles

Behaviour:
- Scoreboard: 16 × 2-bit counters pend[i].
- issue = dec_valid & ~hazard & ~flush_active.
- pend[dec_rd] +1 when issue & dec_rwrite; pend[wb_rd] −1 when wb_rwrite.
- Increment and decrement on the same register in the same cycle: count unchanged.
- Decrement at 0 is ignored. Increment at 3 is ignored. Neither occurs legally: at most 3 writes are in flight (EXE, MEM, WB).
- busy_mask[i] = (pend[i] != 0), registered.
- hazard = dec_valid & ((dec_use1 & pend[dec_rs1]!=0) | (dec_use2 & pend[dec_rs2]!=0)), combinational from registered pend and current decode fields.
- The register file is written at the clock edge. A register being written back in the current cycle is still a hazard; the stall is released the following cycle.
- When hazard is asserted:
  - stall_fetch=1 and bubble_exe=1 in the same cycle.
  - No scoreboard increment occurs.
  - branch_taken is ignored, because branch operands are not yet valid.
- FSM states:
  - RUN: flush_deco = branch_taken & dec_valid & ~hazard, combinational. If FLUSH_CYCLES>1, go to FLUSH with fcnt=FLUSH_CYCLES−1; otherwise stay in RUN.
  - FLUSH: flush_deco=1, flush_active=1, stall_fetch=0. fcnt decrements each cycle; return to RUN when fcnt reaches 1→0. branch_taken is ignored while in FLUSH.
- Flush and hazard cannot both apply to the same instruction; hazard takes priority.
- stall_count increments each cycle stall_fetch=1 and saturates at all-ones.
- Consecutive-stall counter increments while stall_fetch=1 and clears when stall_fetch=0. deadlock sets when it reaches TIMEOUT and clears only on reset.
- Reset (synchronous, any state, including mid-flush or mid-stall):
  - All pend = 0, busy_mask = 0, FSM = RUN.
  - stall_count = 0, deadlock = 0, fcnt = 0.
  - Outputs stall_fetch, bubble_exe and flush_deco are 0 while reset is high.
- Latency:
  - Hazard detection and taken-branch flush: 0 cycles (same cycle).
  - Scoreboard update: visible the next cycle.

Test Plan:
- Reset then idle, dec_valid=0 → all outputs 0, busy_mask=0x0000, stall_count=0.
- ADD r3 issues (dec_rd=3, rwrite=1), next instruction reads r3 → busy_mask=0x0008; stall_fetch=bubble_exe=1 for 3 cycles. Cycle wb_rwrite with wb_rd=3 still stalls; stall releases next cycle; stall_count=3.
- Back-to-back writes to r5 then r5 again → pend[5]=2. First wb_rd=5 leaves busy_mask bit5=1; second clears it. Same-cycle inc+dec on r5 → count unchanged.
- branch_taken=1 with no hazard, FLUSH_CYCLES=1 → flush_deco=1 that cycle only, stall_fetch=0. With FLUSH_CYCLES=3 → flush_deco high 3 consecutive cycles; branch_taken during FLUSH is ignored.
- branch_taken=1 while rs1 pending → flush_deco=0 and stall asserted. After the stall clears, branch_taken=1 gives flush_deco=1.
- Hold dec_use1=1 on a pending register with wb never firing → deadlock=1 after 8 stall cycles and stays 1. Reset asserted mid-stall → everything 0 the cycle after.
